// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

    // Frame sequencer states, exported on the framer's debug port.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    // Baud-rate generator select codes (s1:s0).
    localparam logic [1:0] BAUD_SEL_4800  = 2'b00;
    localparam logic [1:0] BAUD_SEL_9600  = 2'b01;
    localparam logic [1:0] BAUD_SEL_19200 = 2'b10;
    localparam logic [1:0] BAUD_SEL_38400 = 2'b11;

    // Nominal bit periods in microseconds for each select code.
    localparam int BAUD_US_4800  = 208;
    localparam int BAUD_US_9600  = 104;
    localparam int BAUD_US_19200 = 52;
    localparam int BAUD_US_38400 = 26;

    // Parity mode encodings.
    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    // Bit period (us) for a given baud select code.
    function automatic int baud_period_us(input logic [1:0] sel);
        case (sel)
            BAUD_SEL_4800:  return BAUD_US_4800;
            BAUD_SEL_9600:  return BAUD_US_9600;
            BAUD_SEL_19200: return BAUD_US_19200;
            default:        return BAUD_US_38400;
        endcase
    endfunction

    // Parity over the low data_bits bits of data; even mode returns the XOR.
    function automatic logic frame_parity(input logic [8:0] data,
                                          input int data_bits,
                                          input logic mode);
        logic p;
        p = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (i < data_bits) begin
                p = p ^ data[i];
            end
        end
        return (mode == PARITY_EVEN) ? p : ~p;
    endfunction

endpackage

// File: rtl/uart_tx_hold.sv
// One-entry holding buffer between the byte producer and the frame shifter.
//
// Handshake: a word transfers on a rising edge where in_valid && in_ready.
// in_ready is the inverse of the registered hold_valid flag, so it never
// depends combinationally on in_valid. The producer may drop or change
// in_valid/in_data freely while in_ready is low. pop empties the buffer and
// is only asserted while hold_valid is set, so a load and a pop can never
// land on the same edge.
module uart_tx_hold #(
    parameter int WIDTH = 8
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic             pop,
    output logic             hold_valid,
    output logic [WIDTH-1:0] hold_data
);

    logic accept;

    assign in_ready = !hold_valid;
    assign accept   = in_valid && in_ready;

    // Occupancy flag and payload: fill on accept, empty on pop.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            hold_valid <= 1'b0;
            hold_data  <= '0;
        end else begin
            if (accept) begin
                hold_valid <= 1'b1;
                hold_data  <= in_data;
            end else if (pop) begin
                hold_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmit framer: start bit, LSB-first data, optional parity, stop
// bit(s). Every bit boundary is paced by the external baud_tick strobe and
// the line is driven from a register.
module uart_tx_framer
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk_in,
    input  logic                 rst,
    input  logic                 baud_tick,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done,
    output tx_state_e            state_dbg
);

    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_BITS - 1);
    localparam logic [CNT_W-1:0] LAST_STOP = CNT_W'(STOP_BITS - 1);
    localparam logic HAS_PARITY  = (PARITY_EN != 0);
    localparam logic PARITY_MODE = (PARITY_ODD != 0) ? uart_pkg::PARITY_ODD
                                                     : uart_pkg::PARITY_EVEN;

    tx_state_e             state_q;
    tx_state_e             state_d;
    logic [DATA_BITS-1:0]  shift_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  parity_q;
    logic                  tx_q;
    logic                  tx_d;
    logic                  done_q;
    logic                  done_d;
    logic                  pop;
    logic                  hold_valid;
    logic [DATA_BITS-1:0]  hold_data;
    logic                  last_data;
    logic                  last_stop;

    uart_tx_hold #(
        .WIDTH(DATA_BITS)
    ) u_hold (
        .clk_in     (clk_in),
        .rst        (rst),
        .in_valid   (tx_valid),
        .in_data    (tx_data),
        .in_ready   (tx_ready),
        .pop        (pop),
        .hold_valid (hold_valid),
        .hold_data  (hold_data)
    );

    assign last_data = (cnt_q == LAST_DATA);
    assign last_stop = (cnt_q == LAST_STOP);

    // State register.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: the sequencer only advances on baud ticks.
    always_comb begin
        state_d = state_q;
        if (baud_tick) begin
            case (state_q)
                IDLE:    if (hold_valid) state_d = START;
                START:   state_d = DATA;
                DATA:    if (last_data) state_d = HAS_PARITY ? PARITY : STOP;
                PARITY:  state_d = STOP;
                STOP:    if (last_stop) state_d = hold_valid ? START : IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Output logic: next line level, end-of-frame pulse and buffer pop.
    always_comb begin
        tx_d   = tx_q;
        done_d = 1'b0;
        pop    = 1'b0;
        if (baud_tick) begin
            case (state_q)
                IDLE: begin
                    if (hold_valid) begin
                        tx_d = 1'b0;
                        pop  = 1'b1;
                    end
                end
                START:  tx_d = shift_q[0];
                DATA:   tx_d = last_data ? (HAS_PARITY ? parity_q : 1'b1) : shift_q[1];
                PARITY: tx_d = 1'b1;
                STOP: begin
                    tx_d = 1'b1;
                    if (last_stop) begin
                        done_d = 1'b1;
                        if (hold_valid) begin
                            tx_d = 1'b0;
                            pop  = 1'b1;
                        end
                    end
                end
                default: tx_d = 1'b1;
            endcase
        end
    end

    // Datapath: line register, done pulse, shifter, parity snapshot, counter.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            tx_q     <= 1'b1;
            done_q   <= 1'b0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            tx_q   <= tx_d;
            done_q <= done_d;
            if (pop) begin
                // Parity is fixed from the captured byte, not the moving shifter.
                shift_q  <= hold_data;
                parity_q <= frame_parity(9'(hold_data), DATA_BITS, PARITY_MODE);
                cnt_q    <= '0;
            end else if (baud_tick) begin
                case (state_q)
                    START: cnt_q <= '0;
                    DATA: begin
                        shift_q <= shift_q >> 1;
                        cnt_q   <= last_data ? '0 : cnt_q + 1'b1;
                    end
                    STOP:    cnt_q <= last_stop ? '0 : cnt_q + 1'b1;
                    default: cnt_q <= '0;
                endcase
            end
        end
    end

    assign tx        = tx_q;
    assign tx_busy   = (state_q != IDLE);
    assign tx_done   = done_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_uart_tx_framer.sv
// Bench for uart_tx_framer: three instances (even parity / odd parity /
// no parity with two stops) share one stimulus stream and are compared
// every cycle against a frame-level reference model.
module tb_uart_tx_framer;

    logic       clk_in = 1'b0;
    logic       rst;
    logic       baud_tick;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic [2:0] rdy;
    logic [2:0] txl;
    logic [2:0] busy;
    logic [2:0] done;
    uart_pkg::tx_state_e dbg [3];

    int errors = 0;
    int checks = 0;
    int tick_mode = 3;     // 0: every 16 clocks, 1: random, 2: every clock, 3: none
    int tick_cnt = 0;
    int done_cnt = 0;
    bit chk_en = 1'b0;

    // ---------------- clock / reset ----------------
    always #5 clk_in = ~clk_in;

    uart_tx_framer u_dut0 (
        .clk_in(clk_in), .rst(rst), .baud_tick(baud_tick), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(rdy[0]), .tx(txl[0]), .tx_busy(busy[0]),
        .tx_done(done[0]), .state_dbg(dbg[0])
    );
    uart_tx_framer #(.PARITY_ODD(1)) u_dut1 (
        .clk_in(clk_in), .rst(rst), .baud_tick(baud_tick), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(rdy[1]), .tx(txl[1]), .tx_busy(busy[1]),
        .tx_done(done[1]), .state_dbg(dbg[1])
    );
    uart_tx_framer #(.PARITY_EN(0), .STOP_BITS(2)) u_dut2 (
        .clk_in(clk_in), .rst(rst), .baud_tick(baud_tick), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(rdy[2]), .tx(txl[2]), .tx_busy(busy[2]),
        .tx_done(done[2]), .state_dbg(dbg[2])
    );

    // ---------------- check helpers ----------------
    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // ---------------- reference model ----------------
    int   p_par_en [3] = '{1, 1, 0};
    int   p_odd    [3] = '{0, 1, 0};
    int   p_stop   [3] = '{1, 1, 2};

    logic        m_hold_v [3];
    logic [7:0]  m_hold_d [3];
    logic [15:0] m_frame  [3];
    int          m_left   [3];
    int          m_pos    [3];
    logic        m_line   [3];
    logic        m_busy   [3];
    logic        m_done   [3];

    // Whole frame as a list of line levels, interval 0 first.
    function automatic logic [15:0] build_frame(input int k, input logic [7:0] d);
        logic [15:0] f;
        f = '1;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[1 + i] = d[i];
        if (p_par_en[k] != 0) f[9] = (p_odd[k] != 0) ? ~(^d) : ^d;
        return f;
    endfunction

    function automatic int frame_len(input int k);
        return 9 + p_par_en[k] + p_stop[k];
    endfunction

    // ---------------- scoreboard (instance 0 line decoder) ----------------
    logic [7:0]  exp_q[$];
    logic [10:0] rx_bits;
    int          rx_cnt;

    initial begin
        for (int k = 0; k < 3; k++) begin
            m_hold_v[k] = 1'b0; m_hold_d[k] = '0; m_frame[k] = '1;
            m_left[k] = 0; m_pos[k] = 0;
            m_line[k] = 1'b1; m_busy[k] = 1'b0; m_done[k] = 1'b0;
        end
        rx_cnt = 0;
        rx_bits = '0;
        forever begin
            @(posedge clk_in);
            if (baud_tick) tick_cnt++;
            if (done[0]) done_cnt++;
            for (int k = 0; k < 3; k++) begin
                if (rst) begin
                    m_hold_v[k] = 1'b0;
                    m_left[k] = 0;
                    m_done[k] = 1'b0;
                end else begin
                    logic acc;
                    acc = tx_valid && !m_hold_v[k];
                    m_done[k] = 1'b0;
                    if (baud_tick) begin
                        if (m_left[k] > 0) begin
                            m_left[k]--;
                            m_pos[k]++;
                            if (m_left[k] == 0) m_done[k] = 1'b1;
                        end
                        if (m_left[k] == 0 && m_hold_v[k]) begin
                            m_frame[k] = build_frame(k, m_hold_d[k]);
                            m_left[k] = frame_len(k);
                            m_pos[k] = 0;
                            m_hold_v[k] = 1'b0;
                        end
                    end
                    if (acc) begin
                        m_hold_v[k] = 1'b1;
                        m_hold_d[k] = tx_data;
                    end
                end
                m_busy[k] = (m_left[k] > 0);
                m_line[k] = m_busy[k] ? m_frame[k][m_pos[k]] : 1'b1;
            end
            // Decode instance 0's line one interval per tick.
            if (rst) begin
                rx_cnt = 0;
                exp_q.delete();
            end else begin
                if (tx_valid && rdy[0]) exp_q.push_back(tx_data);
                if (baud_tick && busy[0]) begin
                    rx_bits[rx_cnt] = txl[0];
                    rx_cnt++;
                    if (rx_cnt == 11) begin
                        logic [7:0] e;
                        rx_cnt = 0;
                        if (exp_q.size() == 0) begin
                            timeout("sb_unexpected_frame");
                        end else begin
                            e = exp_q.pop_front();
                            chk("sb_start", 16'(rx_bits[0]), 16'd0);
                            chk("sb_data", 16'(rx_bits[8:1]), 16'(e));
                            chk("sb_parity", 16'(rx_bits[9]), 16'($countones(e) % 2));
                            chk("sb_stop", 16'(rx_bits[10]), 16'd1);
                        end
                    end
                end
            end
        end
    end

    // Every-cycle comparison of all instances against the model.
    always @(negedge clk_in) begin
        if (chk_en) begin
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("tx%0d", k), 16'(txl[k]), 16'(m_line[k]));
                chk($sformatf("busy%0d", k), 16'(busy[k]), 16'(m_busy[k]));
                chk($sformatf("done%0d", k), 16'(done[k]), 16'(m_done[k]));
                chk($sformatf("ready%0d", k), 16'(rdy[k]), 16'(!m_hold_v[k]));
            end
        end
    end

    // ---------------- baud tick source ----------------
    initial begin
        int div;
        div = 0;
        baud_tick = 1'b0;
        forever begin
            @(negedge clk_in);
            case (tick_mode)
                0: begin div++; baud_tick = (div % 16 == 0); end
                1: baud_tick = ($urandom_range(0, 3) == 0);
                2: baud_tick = 1'b1;
                default: baud_tick = 1'b0;
            endcase
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [7:0] d);
        @(negedge clk_in);
        tx_data = d;
        tx_valid = 1'b1;
        for (int n = 0; n < 2000; n++) begin
            if (rdy[0]) begin
                @(negedge clk_in);
                tx_valid = 1'b0;
                return;
            end
            @(negedge clk_in);
        end
        tx_valid = 1'b0;
        timeout("send");
    endtask

    task automatic wait_tick();
        int c;
        c = tick_cnt;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk_in);
            if (tick_cnt != c) return;
        end
        timeout("wait_tick");
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 4000; n++) begin
            @(negedge clk_in);
            if (!busy[0] && rdy[0]) return;
        end
        timeout("wait_idle");
    endtask

    // ---------------- vector table ----------------
    typedef struct packed {
        logic [7:0]       data;
        logic [2:0][10:0] fr;   // per instance, bit i = line level in interval i
    } vec_t;

    // Hand-given parity bits: pe for even, po for odd.
    function automatic vec_t mk(input logic [7:0] d, input logic pe, input logic po);
        vec_t v;
        v.data  = d;
        v.fr[0] = {1'b1, pe, d, 1'b0};
        v.fr[1] = {1'b1, po, d, 1'b0};
        v.fr[2] = {1'b1, 1'b1, d, 1'b0};
        return v;
    endfunction

    task automatic run_vector(input vec_t v, input string tag);
        int  d0;
        bit  ok;
        send(v.data);
        chk({tag, "_no_early_start"}, 16'(busy[0]), 16'd0);
        chk({tag, "_idle_line"}, 16'(txl[0]), 16'd1);
        d0 = done_cnt;
        ok = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (busy[0]) begin ok = 1'b1; break; end
            @(negedge clk_in);
        end
        if (!ok) timeout({tag, "_start"});
        for (int i = 0; i < 11; i++) begin
            if (i > 0) wait_tick();
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("%s_i%0d_tx%0d", tag, i, k), 16'(txl[k]), 16'(v.fr[k][i]));
                chk($sformatf("%s_i%0d_busy%0d", tag, i, k), 16'(busy[k]), 16'd1);
            end
        end
        wait_tick();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("%s_done%0d", tag, k), 16'(done[k]), 16'd1);
            chk($sformatf("%s_end_busy%0d", tag, k), 16'(busy[k]), 16'd0);
        end
        @(negedge clk_in);
        chk({tag, "_done_one_cycle"}, 16'(done[0]), 16'd0);
        chk({tag, "_done_count"}, 16'(done_cnt - d0), 16'd1);
    endtask

    vec_t vecs [5];

    // ---------------- main sequence ----------------
    initial begin
        int gap, dn, stall;
        bit ok;
        vecs[0] = mk(8'hA5, 1'b0, 1'b1);
        vecs[1] = mk(8'h01, 1'b1, 1'b0);
        vecs[2] = mk(8'h80, 1'b1, 1'b0);
        vecs[3] = mk(8'h7E, 1'b0, 1'b1);
        vecs[4] = mk(8'h3C, 1'b0, 1'b1);

        rst = 1'b1;
        tx_valid = 1'b0;
        tx_data = '0;
        repeat (2) @(negedge clk_in);
        chk_en = 1'b1;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_tx%0d", k), 16'(txl[k]), 16'd1);
            chk($sformatf("rst_busy%0d", k), 16'(busy[k]), 16'd0);
            chk($sformatf("rst_done%0d", k), 16'(done[k]), 16'd0);
            chk($sformatf("rst_ready%0d", k), 16'(rdy[k]), 16'd1);
            chk($sformatf("rst_state%0d", k), 16'(dbg[k]), 16'(uart_pkg::IDLE));
        end

        // Idle ticks with nothing to send.
        tick_mode = 0;
        repeat (48) @(negedge clk_in);
        chk("idle_tx", 16'(txl[0]), 16'd1);
        chk("idle_busy", 16'(busy[0]), 16'd0);

        // Table-driven single frames.
        for (int i = 0; i < 4; i++) run_vector(vecs[i], $sformatf("vec%0d", i));

        // Back-to-back frames: no idle interval between them.
        send(8'h00);
        send(8'hFF);
        gap = 0;
        dn = 0;
        ok = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            if (done[0]) dn++;
            if (dn == 2) begin ok = 1'b1; break; end
            if (!busy[0]) gap++;
            @(negedge clk_in);
        end
        if (!ok) timeout("b2b_done");
        chk("b2b_gap", 16'(gap), 16'd0);
        wait_idle();

        // Backpressure: third byte stalls until hold moves at STOP end.
        send(8'h11);
        send(8'h22);
        @(negedge clk_in);
        tx_data = 8'h33;
        tx_valid = 1'b1;
        stall = 0;
        ok = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (rdy[0]) begin ok = 1'b1; break; end
            stall++;
            @(negedge clk_in);
        end
        if (!ok) timeout("bp_ready");
        chk("bp_ready_at_done", 16'(done[0]), 16'd1);
        chk("bp_stalled", 16'(stall > 32), 16'd1);
        @(negedge clk_in);
        tx_valid = 1'b0;
        wait_idle();
        chk("bp_all_sent", 16'(exp_q.size()), 16'd0);

        // Reset during data bit 3 with a byte held.
        send(8'h5A);
        send(8'hC3);
        ok = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (dbg[0] == uart_pkg::DATA) begin ok = 1'b1; break; end
            @(negedge clk_in);
        end
        if (!ok) timeout("rst_wait_data");
        repeat (3) wait_tick();
        repeat (4) @(negedge clk_in);
        rst = 1'b1;
        @(negedge clk_in);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("abort_tx%0d", k), 16'(txl[k]), 16'd1);
            chk($sformatf("abort_busy%0d", k), 16'(busy[k]), 16'd0);
            chk($sformatf("abort_ready%0d", k), 16'(rdy[k]), 16'd1);
            chk($sformatf("abort_done%0d", k), 16'(done[k]), 16'd0);
        end
        dn = done_cnt;
        repeat (40) @(negedge clk_in);
        chk("abort_no_done", 16'(done_cnt - dn), 16'd0);
        run_vector(vecs[4], "after_rst");

        // Randomized traffic with random, then back-to-back, tick patterns.
        tick_mode = 1;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk_in);
            if (n == 1500) tick_mode = 2;
            if (n == 1700) tick_mode = 1;
            tx_valid = ($urandom_range(0, 2) == 0);
            tx_data = 8'($urandom_range(0, 255));
        end
        @(negedge clk_in);
        tx_valid = 1'b0;
        tick_mode = 0;
        wait_idle();
        repeat (4) @(negedge clk_in);
        chk("rand_all_sent", 16'(exp_q.size()), 16'd0);
        chk("final_tx", 16'(txl[0]), 16'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time bound.
    initial begin
        #2000000;
        errors++;
        checks++;
        $display("FAIL watchdog: simulation did not complete");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_framer.md
Name: uart_tx_framer

Overview:
Serial transmit stage directly downstream of the baud-rate generator. It accepts parallel bytes over a valid/ready handshake and holds one of them in a 1-entry buffer. Each byte is shifted out as a UART frame: start bit, data LSB-first, optional parity, then stop bit(s). Bit timing comes only from a one-cycle baud_tick strobe produced by the generator at the selected rate (4800/9600/19200/38400, set by s1:s0).

Parameters:
DATA_BITS, 8, number of data bits per frame (5..9)
PARITY_EN, 1, 1 = insert parity bit after data
PARITY_ODD, 0, 0 = even parity, 1 = odd parity (ignored if PARITY_EN=0)
STOP_BITS, 1, number of stop bit intervals (1 or 2)

Ports:
clk_in  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
baud_tick  input  1  one-cycle strobe, one per bit period
tx_data  input  DATA_BITS  byte to send, sampled on accept
tx_valid  input  1  tx_data valid
tx_ready  output  1  holding buffer empty; accept = tx_valid && tx_ready
tx  output  1  serial line, registered, idle high
tx_busy  output  1  high while a frame is on the line (START..STOP)
tx_done  output  1  one-cycle pulse when the last stop interval ends

Behaviour:
- Reset (rst=1 at a clock edge): tx=1, tx_busy=0, tx_done=0, hold buffer empty (tx_ready=1 the cycle after reset), state IDLE, bit counter 0. Reset mid-frame aborts the frame: tx returns high the next cycle and any held byte is discarded.
- tx_ready = !hold_valid, driven from the registered flag. An accept loads tx_data into hold on that edge. tx_data is ignored when not accepted.
- FSM states: IDLE, START, DATA, PARITY, STOP. All transitions occur only on edges where baud_tick=1. tx is registered, so each level appears the cycle after the tick and lasts until the next tick.
- IDLE: tx=1. On tick with hold_valid, copy hold to shifter, clear hold_valid, go to START (tx=0). Tick with hold empty: stay.
- START: on tick, go to DATA, drive shifter[0], bit counter=0.
- DATA: on each tick, shift right and increment the counter. After DATA_BITS intervals, go to PARITY if PARITY_EN, else STOP.
- PARITY: drive ^byte (even) or ~^byte (odd). On tick, go to STOP.
- STOP: tx=1 for STOP_BITS intervals. On the tick ending the final interval, pulse tx_done. In the same cycle, go to START if hold_valid (back-to-back frames with no idle gap, hold moves to shifter), else go to IDLE.
- Parity is computed from the byte captured at START, not from the live shifter.
- Accept and hold-to-shifter transfer never coincide in the same cycle (ready depends on registered hold_valid). This gives a one-cycle ready bubble after each transfer, which is required behaviour.
- Latency: byte accepted at cycle N with the FSM in IDLE. The start bit begins the cycle after the first baud_tick at a cycle later than N.
- baud_tick high on consecutive cycles: each high cycle counts as one bit interval; no filtering.
- tx_busy=1 in START, DATA, PARITY, STOP; 0 in IDLE.

Decomposition:
- Package uart_pkg:
  - tx_state_e enum (IDLE, START, DATA, PARITY, STOP)
  - baud select constants BAUD_SEL_4800=2'b00, _9600=2'b01, _19200=2'b10, _38400=2'b11
  - bit periods in us: 208, 104, 52, 26
  - PARITY_EVEN/PARITY_ODD constants
- One sub-module, uart_tx_hold: 1-entry buffer with valid/ready in, load/pop out.
- Shifter, counter and FSM stay in uart_tx_framer.

Test Plan:
- Single frame (default params): baud_tick every 16 clk_in; send 0xA5. tx after ticks = 0 | 1,0,1,0,0,1,0,1 | parity 0 | 1. tx_done pulses once; tx_busy high for exactly 11 intervals.
- Back-to-back: accept 0x00, then 0xFF while busy. The second frame's start bit follows the first stop bit with no idle interval. Both parity bits are 0; two tx_done pulses.
- Backpressure: 3 tx_valid bytes offered while the first frame is on the line. The 2nd is accepted into hold; tx_ready stays 0 and the 3rd is stalled until hold transfers at the STOP-end tick. All three are sent in order.
- Odd parity, no second stop: PARITY_ODD=1, send 0x01 → parity bit 0. PARITY_EN=0, STOP_BITS=2, send 0x01 → 11 intervals, no parity bit, stop held 2 intervals.
- Reset mid-frame: assert rst during DATA bit 3 with a byte held. The next cycle shows tx=1, tx_busy=0, tx_ready=1, with no tx_done. A new byte 0x3C then transmits correctly.
- Idle ticks: ticks with no data keep tx=1 and tx_busy=0. A byte accepted between ticks does not start until the next tick.
